// File: rtl/rf_pkt_pkg.sv
// ============================================================================
//  Module      : rf_pkt_pkg
//  Description : Shared types and constants for the RF frame serializer.
//                Holds the serializer state encoding, the default sync word
//                and the payload lengths of the two frame formats.
//                Optional feature macro: RF_SER_PARITY_EN adds the PAR state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkt_pkg;

    // Default sync word, transmitted MSB first ahead of every frame.
    localparam int                    DEF_SYNC_W    = 8;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_WORD = 8'hA5;

    // Payload lengths: format0 = 8 rows x 10 bits, format1 = 4 rows x 6 bits.
    localparam int F0_PAYLOAD_BITS = 80;
    localparam int F1_PAYLOAD_BITS = 24;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_FMT  = 3'd2,
        S_DATA = 3'd3
`ifdef RF_SER_PARITY_EN
        ,
        S_PAR  = 3'd4
`endif
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_frame_flatten.sv
// ============================================================================
//  Module      : rf_frame_flatten
//  Description : Combinational mapping of a captured frame (packed rows) and
//                its format select onto one flat payload vector, bit 0 first
//                on the line, plus the number of payload bits to send.
//                format0: all rows, all columns (payload == rows).
//                format1: rows 0..F1_ROWS-1, columns 0..F1_COLS-1 only,
//                         packed densely; unused upper bits are zero.
//  Ports       : rows        - captured frame, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//                fmt         - 0 = format0, 1 = format1
//                payload     - flat payload, sent from bit 0 upward
//                payload_len - number of valid payload bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_frame_flatten #(
    parameter int DATA_WIDTH = 10,
    parameter int DATA_DEPTH = 8,
    parameter int F1_ROWS    = 4,
    parameter int F1_COLS    = 6,
    parameter int PAY_W      = DATA_WIDTH * DATA_DEPTH,
    parameter int LEN_W      = $clog2(PAY_W + 1)
) (
    input  logic [PAY_W-1:0] rows,
    input  logic             fmt,
    output logic [PAY_W-1:0] payload,
    output logic [LEN_W-1:0] payload_len
);

    localparam int c_F1_BITS = F1_ROWS * F1_COLS;

    logic [PAY_W-1:0] w_f1_payload;

    // Format1 keeps only the low F1_COLS bits of each of the first F1_ROWS
    // rows and packs them back to back, so no padding ever reaches the line.
    for (genvar r = 0; r < F1_ROWS; r++) begin : g_row
        for (genvar c = 0; c < F1_COLS; c++) begin : g_col
            assign w_f1_payload[r*F1_COLS + c] = rows[r*DATA_WIDTH + c];
        end
    end

    if (c_F1_BITS < PAY_W) begin : g_pad
        assign w_f1_payload[PAY_W-1:c_F1_BITS] = '0;
    end

    assign payload     = fmt ? w_f1_payload : rows;
    assign payload_len = fmt ? LEN_W'(c_F1_BITS) : LEN_W'(PAY_W);

endmodule

`default_nettype wire

// File: rtl/rf_frame_serializer.sv
// ============================================================================
//  Module      : rf_frame_serializer
//  Description : Accepts one scrambled frame per valid/ready handshake and
//                transmits it as a single-bit stream: sync word (MSB first),
//                format bit, then the payload (row 0 upward, LSB first).
//                Each line bit is held until the first bit_en strobe seen
//                while it is on the line.
//                Optional feature macro: RF_SER_PARITY_EN appends one even
//                parity bit covering the payload bits only.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                bit_en        - strobe that ends the current line bit
//                in_valid/in_ready - frame handshake
//                enc_used      - format select (0 = 80-bit, 1 = 24-bit payload)
//                par_in        - frame rows, row 0 at the low index
//                tx_bit        - serial line (idle mark = 1)
//                tx_active     - high while a frame is on the line
//                tx_done       - one-cycle pulse after the last bit
//                frame_cnt     - frames completely sent, wraps at 16 bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_frame_serializer
    import rf_pkt_pkg::*;
#(
    parameter int                DATA_WIDTH = 10,
    parameter int                DATA_DEPTH = 8,
    parameter int                SYNC_W     = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
    parameter int                F1_ROWS    = 4,
    parameter int                F1_COLS    = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bit_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             enc_used,
    input  logic [DATA_DEPTH*DATA_WIDTH-1:0] par_in,
    output logic                             tx_bit,
    output logic                             tx_active,
    output logic                             tx_done,
    output logic [15:0]                      frame_cnt
);

    localparam int c_PAY_W = DATA_DEPTH * DATA_WIDTH;
    localparam int c_CNT_W = $clog2(c_PAY_W);
    localparam int c_LEN_W = $clog2(c_PAY_W + 1);

    ser_state_t           r_state;
    ser_state_t           w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_next_cnt;
    logic [SYNC_W-1:0]    r_sync;
    logic                 r_fmt;
    logic [c_PAY_W-1:0]   r_rows;
    logic                 r_tx_done;
    logic [15:0]          r_frame_cnt;

    logic                 w_capture;
    logic                 w_done;
    logic                 w_tx_bit;
    logic                 w_in_ready;
    logic                 w_last_data;
    logic [c_PAY_W-1:0]   w_payload;
    logic [c_LEN_W-1:0]   w_payload_len;

`ifdef RF_SER_PARITY_EN
    logic                 r_par;
    logic                 w_next_par;
`endif

    rf_frame_flatten #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .F1_ROWS    (F1_ROWS),
        .F1_COLS    (F1_COLS),
        .PAY_W      (c_PAY_W),
        .LEN_W      (c_LEN_W)
    ) u_flatten (
        .rows        (r_rows),
        .fmt         (r_fmt),
        .payload     (w_payload),
        .payload_len (w_payload_len)
    );

    // in_ready is forced low while rst is asserted, even though the state
    // register may already read IDLE.
    assign w_in_ready  = (r_state == S_IDLE) && !rst;
    assign w_last_data = ((c_LEN_W'(r_cnt) + c_LEN_W'(1)) == w_payload_len);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_tx_bit     = 1'b1;
`ifdef RF_SER_PARITY_EN
        w_next_par   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                // bit_en is deliberately ignored in the capture cycle.
                if (in_valid && w_in_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = S_SYNC;
                    w_next_cnt   = '0;
                end
            end
            S_SYNC: begin
                w_tx_bit = r_sync[SYNC_W-1];
                if (bit_en) begin
                    if (r_cnt == c_CNT_W'(SYNC_W - 1)) begin
                        w_next_state = S_FMT;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            S_FMT: begin
                w_tx_bit = r_fmt;
                if (bit_en) begin
                    w_next_state = S_DATA;
                    w_next_cnt   = '0;
`ifdef RF_SER_PARITY_EN
                    w_next_par   = 1'b0;
`endif
                end
            end
            S_DATA: begin
                w_tx_bit = w_payload[r_cnt];
                if (bit_en) begin
`ifdef RF_SER_PARITY_EN
                    w_next_par = r_par ^ w_payload[r_cnt];
`endif
                    if (w_last_data) begin
                        w_next_cnt = '0;
`ifdef RF_SER_PARITY_EN
                        w_next_state = S_PAR;
`else
                        w_next_state = S_IDLE;
                        w_done       = 1'b1;
`endif
                    end else begin
                        w_next_cnt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
`ifdef RF_SER_PARITY_EN
            S_PAR: begin
                w_tx_bit = r_par;
                if (bit_en) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sync      <= '0;
            r_fmt       <= 1'b0;
            r_rows      <= '0;
            r_tx_done   <= 1'b0;
            r_frame_cnt <= '0;
`ifdef RF_SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_tx_done <= w_done;
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_capture) begin
                r_rows <= par_in;
                r_fmt  <= enc_used;
                r_sync <= SYNC_WORD;
            end else if (r_state == S_SYNC && bit_en) begin
                // Sync word leaves through the MSB of a shift register.
                r_sync <= {r_sync[SYNC_W-2:0], 1'b0};
            end
`ifdef RF_SER_PARITY_EN
            r_par <= w_next_par;
`endif
        end
    end

    assign in_ready  = w_in_ready;
    assign tx_bit    = w_tx_bit;
    assign tx_active = (r_state != S_IDLE);
    assign tx_done   = r_tx_done;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rf_frame_serializer.sv
// ============================================================================
//  Module      : tb_rf_frame_serializer
//  Description : Self-checking bench for rf_frame_serializer. Each accepted
//                frame's expected line bits are queued; a negedge monitor
//                compares tx_bit against the queue head every active cycle
//                and pops on bit_en.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rf_frame_serializer;
    import rf_pkt_pkg::*;

    localparam int W = 10;
    localparam int D = 8;
`ifdef RF_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_en = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         enc_used = 1'b0;
    logic [D*W-1:0] par_in = '0;
    logic         tx_bit;
    logic         tx_active;
    logic         tx_done;
    logic [15:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    bit q[$];
    int be_period = 4;
    int be_cnt = 0;
    bit cap_seen = 0;
    bit done_due = 0;
    int exp_frames = 0;
    int done_seen = 0;
    int caps = 0;
    int cap_in_done = 0;
    int line_bits = 0;
    int last_line_bits = 0;
    bit last_bit_v = 0;

    always #5 clk = ~clk;

    rf_frame_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_used  (enc_used),
        .par_in    (par_in),
        .tx_bit    (tx_bit),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .frame_cnt (frame_cnt)
    );

    // Expected line bits for one frame: sync MSB first, format bit, payload.
    function automatic void push_frame(input logic [D*W-1:0] rows, input logic fmt);
        logic [7:0] sw;
        bit p;
        sw = 8'hA5;
        p  = 1'b0;
        for (int i = 7; i >= 0; i--) q.push_back(sw[i]);
        q.push_back(fmt);
        if (!fmt) begin
            for (int r = 0; r < D; r++)
                for (int c = 0; c < W; c++) begin
                    q.push_back(rows[r*W + c]);
                    p ^= rows[r*W + c];
                end
        end else begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 6; c++) begin
                    q.push_back(rows[r*W + c]);
                    p ^= rows[r*W + c];
                end
        end
        if (P == 1) q.push_back(p);
    endfunction

    // bit_en generator; phase restarts on each capture so the first bit of a
    // frame is held for a full period.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cap_seen) begin
                cap_seen = 0;
                be_cnt   = 0;
            end
            be_cnt++;
            if (be_cnt >= be_period) begin
                bit_en = 1'b1;
                be_cnt = 0;
            end else begin
                bit_en = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            done_due   = 0;
            exp_frames = 0;
            line_bits  = 0;
            q.delete();
        end else begin
            checks++;
            if (tx_done !== done_due) begin
                errors++;
                $display("FAIL tx_done: got %b expected %b at %0t", tx_done, done_due, $time);
            end
            if (tx_done) begin
                done_seen++;
                last_line_bits = line_bits;
            end
            if (done_due) begin
                checks++;
                if (frame_cnt !== exp_frames[15:0]) begin
                    errors++;
                    $display("FAIL frame_cnt_at_done: got %0d expected %0d", frame_cnt, exp_frames);
                end
            end
            done_due = 0;
            checks++;
            if (in_ready !== !tx_active) begin
                errors++;
                $display("FAIL ready_vs_active: in_ready %b tx_active %b at %0t", in_ready, tx_active, $time);
            end
            if (tx_active) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_line_bit: tx_bit %b with no expected bit at %0t", tx_bit, $time);
                end else begin
                    if (tx_bit !== q[0]) begin
                        errors++;
                        $display("FAIL tx_bit: got %b expected %b at %0t", tx_bit, q[0], $time);
                    end
                    if (bit_en) begin
                        line_bits++;
                        last_bit_v = tx_bit;
                        void'(q.pop_front());
                        if (q.size() == 0) begin
                            done_due = 1;
                            exp_frames++;
                        end
                    end
                end
            end else begin
                checks++;
                if (tx_bit !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_mark: tx_bit %b expected 1 at %0t", tx_bit, $time);
                end
            end
            if (in_valid && in_ready) begin
                caps++;
                if (tx_done) cap_in_done++;
                push_frame(par_in, enc_used);
                line_bits = 0;
                cap_seen  = 1;
            end
        end
    end

    task automatic wait_caps(input int target, input int budget, input string tag);
        int n = 0;
        while (caps < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (caps < target) begin
            errors++;
            $display("FAIL %s_capture: captures %0d expected %0d", tag, caps, target);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((tx_active || q.size() != 0) && n < budget);
        checks++;
        if (tx_active || q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: active %b bits left %0d expected 0", tag, tx_active, q.size());
        end
    endtask

    task automatic send_frame(input logic [D*W-1:0] rows, input logic fmt, input int period);
        int c0 = caps;
        logic [95:0] t;
        @(posedge clk); #1;
        be_period = period;
        par_in    = rows;
        enc_used  = fmt;
        in_valid  = 1'b1;
        wait_caps(c0 + 1, 50, "send");
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scribble the inputs while busy; the captured frame must not change.
        t = {$urandom(), $urandom(), $urandom()};
        par_in   = t[D*W-1:0];
        enc_used = ~fmt;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; be_period = 4;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (tx_bit !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: bit %b active %b done %b cnt %0d expected 1 0 0 0",
                     tx_bit, tx_active, tx_done, frame_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (frame_cnt !== 16'd0 || tx_active !== 1'b0) begin
            errors++; $display("FAIL idle_no_valid: cnt %0d active %b expected 0 0", frame_cnt, tx_active);
        end
    endtask

    task automatic test_format0();
        logic [D*W-1:0] rows;
        int d0 = done_seen;
        for (int k = 0; k < D; k++) rows[k*W +: W] = (k % 2 == 0) ? 10'h3FF : 10'h000;
        send_frame(rows, 1'b0, 1);
        wait_done(400, "f0");
        checks++;
        if (done_seen !== d0 + 1) begin
            errors++; $display("FAIL f0_done_count: got %0d expected %0d", done_seen - d0, 1);
        end
        checks++;
        if (last_line_bits !== 89 + P) begin
            errors++; $display("FAIL f0_line_bits: got %0d expected %0d", last_line_bits, 89 + P);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++; $display("FAIL f0_frame_cnt: got %0d expected 1", frame_cnt);
        end
    endtask

    task automatic test_format1();
        logic [D*W-1:0] rows;
        int d0 = done_seen;
        for (int k = 0; k < D; k++) rows[k*W +: W] = (k < 4) ? 10'h02A : 10'h155;
        send_frame(rows, 1'b1, 3);
        wait_done(400, "f1");
        checks++;
        if (done_seen !== d0 + 1) begin
            errors++; $display("FAIL f1_done_count: got %0d expected %0d", done_seen - d0, 1);
        end
        checks++;
        if (last_line_bits !== 33 + P) begin
            errors++; $display("FAIL f1_line_bits: got %0d expected %0d", last_line_bits, 33 + P);
        end
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++; $display("FAIL f1_frame_cnt: got %0d expected 2", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [95:0] t;
        int c0 = caps;
        int d0 = done_seen;
        int b0 = cap_in_done;
        @(posedge clk); #1;
        be_period = 1;
        t = {$urandom(), $urandom(), $urandom()};
        par_in = t[D*W-1:0]; enc_used = 1'b1; in_valid = 1'b1;
        wait_caps(c0 + 1, 50, "b2b_first");
        @(posedge clk); #1;
        t = {$urandom(), $urandom(), $urandom()};
        par_in = t[D*W-1:0]; enc_used = 1'b0;
        wait_caps(c0 + 2, 200, "b2b_second");
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(400, "b2b");
        checks++;
        if (cap_in_done !== b0 + 1) begin
            errors++; $display("FAIL b2b_capture_in_done_cycle: got %0d expected 1", cap_in_done - b0);
        end
        checks++;
        if (done_seen !== d0 + 2) begin
            errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_seen - d0);
        end
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++; $display("FAIL b2b_frame_cnt: got %0d expected 4", frame_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [95:0] t;
        int n = 0;
        int d0;
        t = {$urandom(), $urandom(), $urandom()};
        send_frame(t[D*W-1:0], 1'b0, 2);
        while (line_bits < 49 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (line_bits < 49) begin
            errors++; $display("FAIL midrst_reach: line bits %0d expected 49", line_bits);
        end
        d0 = done_seen;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (tx_bit !== 1'b1 || tx_active !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_outputs: bit %b active %b cnt %0d expected 1 0 0", tx_bit, tx_active, frame_cnt);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (done_seen !== d0) begin
            errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen - d0);
        end
        t = {$urandom(), $urandom(), $urandom()};
        send_frame(t[D*W-1:0], 1'b1, 2);
        wait_done(400, "midrst_next");
        checks++;
        if (frame_cnt !== 16'd1 || last_line_bits !== 33 + P) begin
            errors++;
            $display("FAIL midrst_next_frame: cnt %0d bits %0d expected 1 %0d", frame_cnt, last_line_bits, 33 + P);
        end
    endtask

`ifdef RF_SER_PARITY_EN
    task automatic test_parity();
        logic [D*W-1:0] rows;
        // Low 6 bits hold seven 1s in total; upper bits are ignored.
        rows = '0;
        rows[0*W +: W] = 10'h3C7;
        rows[1*W +: W] = 10'h003;
        rows[2*W +: W] = 10'h3C1;
        rows[3*W +: W] = 10'h020;
        send_frame(rows, 1'b1, 2);
        wait_done(400, "par");
        checks++;
        if (last_line_bits !== 34) begin
            errors++; $display("FAIL par_line_bits: got %0d expected 34", last_line_bits);
        end
        checks++;
        if (last_bit_v !== 1'b1) begin
            errors++; $display("FAIL par_bit: got %b expected 1", last_bit_v);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_format0();
        test_format1();
        test_back_to_back();
        test_mid_reset();
`ifdef RF_SER_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
